// File: rtl/data_mem_responder_pkg.sv
// Shared request/response structs and FSM state encoding for the data memory responder.
package data_mem_responder_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic        valid;
        logic        yumi;
        logic [31:0] read_data;
    } mem_out_s;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-side bundle: request struct plus byte address toward the memory, response struct back.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    mem_in_s     to_mem;
    logic [31:0] addr;
    mem_out_s    from_mem;

    modport master (output to_mem, output addr, input from_mem);
    modport slave  (input to_mem, input addr, output from_mem);
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Word-organised storage: byte-enabled synchronous write, combinational read, never reset.
module dmem_array #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic [3:0]              i_be,
    input  logic [addr_width_p-1:0] i_idx,
    input  logic [31:0]             i_wdata,
    output logic [31:0]             o_rdata
);

    logic [31:0] r_mem [0:(1 << addr_width_p)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: accept, wait latency_p cycles, then hold the
// response until the core yumis it; requests arriving while busy are simply not acknowledged.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o
);

    localparam logic [3:0] LAT_M1 = 4'(latency_p - 1);
    localparam int         AMSB   = addr_width_p + 1;

    state_e        r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [AMSB:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_wen;
    logic          r_bnw;
    logic [31:0]   r_rdata, w_rdata_nxt;

    logic          w_accept;
    logic          w_go_resp;
    logic [AMSB:0] w_op_addr;
    logic [31:0]   w_op_wdata;
    logic          w_op_wen;
    logic          w_op_bnw;
    logic [1:0]    w_lane;
    logic [31:0]   w_word;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_arr_wdata;
    logic          w_unused_addr;

    assign w_unused_addr = ^addr_i[31:AMSB+1];

    assign w_accept = (r_state == ST_IDLE) && to_mem_i.valid;

    // With latency_p=1 the RESP transition happens on the accept edge itself, so the
    // operation must come straight from the inputs rather than the capture registers.
    assign w_op_addr  = (r_state == ST_IDLE) ? addr_i[AMSB:0]         : r_addr;
    assign w_op_wdata = (r_state == ST_IDLE) ? to_mem_i.write_data    : r_wdata;
    assign w_op_wen   = (r_state == ST_IDLE) ? to_mem_i.wen           : r_wen;
    assign w_op_bnw   = (r_state == ST_IDLE) ? to_mem_i.byte_not_word : r_bnw;
    assign w_lane     = w_op_addr[1:0];

    always_comb begin
        w_load = w_word;
        if (w_op_bnw) begin
            case (w_lane)
                2'd0:    w_load = {24'd0, w_word[7:0]};
                2'd1:    w_load = {24'd0, w_word[15:8]};
                2'd2:    w_load = {24'd0, w_word[23:16]};
                default: w_load = {24'd0, w_word[31:24]};
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rdata;
        w_go_resp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (to_mem_i.valid) begin
                    w_cnt_nxt = LAT_M1;
                    if (latency_p == 1) begin
                        w_state_nxt = ST_RESP;
                        w_go_resp   = 1'b1;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_RESP;
                    w_go_resp   = 1'b1;
                end
            end
            ST_RESP: begin
                if (to_mem_i.yumi) begin
                    w_state_nxt = ST_IDLE;
                    w_rdata_nxt = 32'd0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_go_resp) begin
            w_rdata_nxt = w_op_wen ? 32'd0 : w_load;
        end
    end

    // Reset gates the write so an in-flight store is dropped rather than landing late.
    assign w_be        = (w_go_resp && w_op_wen && reset)
                         ? (w_op_bnw ? lane_be(w_lane) : 4'hF) : 4'h0;
    assign w_arr_wdata = w_op_bnw ? {4{w_op_wdata[7:0]}} : w_op_wdata;

    dmem_array #(
        .addr_width_p (addr_width_p)
    ) u_dmem_array (
        .clk     (clk),
        .i_be    (w_be),
        .i_idx   (w_op_addr[AMSB:2]),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_wen   <= 1'b0;
            r_bnw   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
            if (w_accept) begin
                r_addr  <= addr_i[AMSB:0];
                r_wdata <= to_mem_i.write_data;
                r_wen   <= to_mem_i.wen;
                r_bnw   <= to_mem_i.byte_not_word;
            end
        end
    end

    always_comb begin
        from_mem_o           = '0;
        from_mem_o.valid     = (r_state == ST_RESP);
        from_mem_o.yumi      = w_accept && reset;
        from_mem_o.read_data = r_rdata;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench: two responders (latency 2 and 1) checked against a word-array reference model.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();

    mem_in_s     req  [2];
    logic [31:0] raddr[2];

    assign if0.to_mem = req[0];
    assign if0.addr   = raddr[0];
    assign if1.to_mem = req[1];
    assign if1.addr   = raddr[1];

    data_mem_responder #(.addr_width_p(10), .latency_p(2)) dut0 (
        .clk(clk), .reset(reset), .to_mem_i(if0.to_mem), .addr_i(if0.addr), .from_mem_o(if0.from_mem));
    data_mem_responder #(.addr_width_p(10), .latency_p(1)) dut1 (
        .clk(clk), .reset(reset), .to_mem_i(if1.to_mem), .addr_i(if1.addr), .from_mem_o(if1.from_mem));

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [2][1024];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic mem_out_s get_out(input int u);
        return (u == 1) ? if1.from_mem : if0.from_mem;
    endfunction

    // Reference: plain word array, byte lanes handled with shifts and masks.
    function automatic logic [31:0] model_op(input int u, input bit wen, input bit bnw,
                                             input logic [31:0] a, input logic [31:0] d);
        int idx = int'(a[11:2]);
        int sh  = 8 * int'(a[1:0]);
        if (wen) begin
            if (bnw) mdl[u][idx] = (mdl[u][idx] & ~(32'hFF << sh)) | ({24'd0, d[7:0]} << sh);
            else     mdl[u][idx] = d;
            return 32'd0;
        end
        return bnw ? ((mdl[u][idx] >> sh) & 32'hFF) : mdl[u][idx];
    endfunction

    task automatic scramble(input int u, input bit allow_yumi);
        req[u].valid      = 1'($urandom);
        req[u].write_data = $urandom;
        req[u].wen        = 1'($urandom);
        req[u].yumi       = allow_yumi ? 1'($urandom) : 1'b0;
        raddr[u]          = $urandom;
    endtask

    // Called just after a negedge with the unit idle; returns just after a negedge, unit idle.
    task automatic txn(input int u, input bit wen, input bit bnw, input logic [31:0] a,
                       input logic [31:0] d, input int hold);
        logic [31:0] exp = model_op(u, wen, bnw, a, d);
        int lat = (u == 1) ? 1 : 2;
        int n = 0;
        int c = 1;
        mem_out_s o;
        req[u].valid = 1'b1; req[u].wen = wen; req[u].byte_not_word = bnw;
        req[u].write_data = d; req[u].yumi = 1'b0; raddr[u] = a;
        #1;
        while (!get_out(u).yumi && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_wait", n, 0);
        @(negedge clk);
        scramble(u, 1'b1);
        #1;
        o = get_out(u);
        while (!o.valid && c < 20) begin
            chk("busy_yumi", {31'd0, o.yumi}, 0);
            chk("busy_rdata", o.read_data, 0);
            @(negedge clk);
            scramble(u, 1'b1);
            #1; c++;
            o = get_out(u);
        end
        req[u].yumi = 1'b0;
        chk("latency", c, lat);
        chk("rdata", o.read_data, exp);
        chk("resp_yumi", {31'd0, o.yumi}, 0);
        repeat (hold) begin
            @(negedge clk);
            scramble(u, 1'b0);
            #1;
            o = get_out(u);
            chk("hold_valid", {31'd0, o.valid}, 1);
            chk("hold_rdata", o.read_data, exp);
            chk("hold_yumi", {31'd0, o.yumi}, 0);
        end
        req[u].yumi = 1'b1;
        #1;
        chk("yumi_cycle_noacc", {31'd0, get_out(u).yumi}, 0);
        @(negedge clk);
        req[u].yumi = 1'b0; req[u].valid = 1'b0;
        #1;
        o = get_out(u);
        chk("idle_valid", {31'd0, o.valid}, 0);
        chk("idle_rdata", o.read_data, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r = $urandom;
        return {r[31:12], 4'd0, r[7:0]};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        req[0] = '0; req[1] = '0; raddr[0] = 32'd0; raddr[1] = 32'd0;
        reset = 1'b0;
        req[0].valid = 1'b1;
        #2;
        chk("rst_valid", {31'd0, if0.from_mem.valid}, 0);
        chk("rst_yumi", {31'd0, if0.from_mem.yumi}, 0);
        chk("rst_rdata", if0.from_mem.read_data, 0);
        req[0].valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;

        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 64; i++)
                txn(u, 1'b1, 1'b0, 32'(i * 4), $urandom, 0);

        txn(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 0);
        chk("dir_word_load", mdl[0][16], 32'hDEADBEEF);

        txn(0, 1'b1, 1'b0, 32'h80, 32'h11223344, 0);
        txn(0, 1'b1, 1'b1, 32'h82, 32'h000000AB, 0);
        txn(0, 1'b0, 1'b1, 32'h82, 32'h0, 1);
        txn(0, 1'b0, 1'b1, 32'h83, 32'h0, 0);
        txn(0, 1'b0, 1'b0, 32'h80, 32'h0, 0);
        chk("dir_byte_merge", mdl[0][32], 32'h11AB3344);

        txn(0, 1'b0, 1'b0, 32'h80, 32'h0, 5);
        txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 0);

        txn(0, 1'b1, 1'b0, 32'h1000, 32'h5, 0);
        txn(0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        chk("dir_wrap", mdl[0][0], 32'h5);

        // Abandoned store: reset lands in the BUSY cycle, before the write edge.
        txn(0, 1'b1, 1'b0, 32'h10, 32'h99, 0);
        req[0].valid = 1'b1; req[0].wen = 1'b1; req[0].byte_not_word = 1'b0;
        req[0].write_data = 32'h77; raddr[0] = 32'h10;
        #1;
        chk("rst_store_accept", {31'd0, if0.from_mem.yumi}, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, if0.from_mem.valid}, 0);
        chk("midrst_yumi", {31'd0, if0.from_mem.yumi}, 0);
        chk("midrst_rdata", if0.from_mem.read_data, 0);
        @(negedge clk);
        reset = 1'b1; req[0].valid = 1'b0;
        #1;
        txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 0);
        chk("midrst_keep", mdl[0][4], 32'h99);

        for (int i = 0; i < 8; i++)
            txn(1, 1'($urandom), 1'($urandom), rand_addr(), $urandom, $urandom_range(0, 2));

        for (int i = 0; i < 300; i++)
            txn($urandom_range(0, 1), 1'($urandom), 1'($urandom), rand_addr(), $urandom,
                $urandom_range(0, 3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
